// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the instruction cache: word type, address split, frame layout.
// ICACHE_SETS is the default frame count; the cache itself is parameterised by SETS.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef enum logic {
    COMPARE = 1'b0,
    FETCH   = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_frames.sv
// Direct-mapped frame store: one combinational read port by index, one write port,
// valid bits cleared asynchronously by reset.
module icache_frames
  import cpu_types_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output word_t            rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  word_t            wr_data
);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags  [SETS];
  word_t            datas [SETS];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) valid <= '0;
    else if (wr_en) valid[wr_idx] <= 1'b1;
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone make stale contents unreachable.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tags[wr_idx]  <= wr_tag;
      datas[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = datas[rd_idx];

endmodule

// File: rtl/icache.sv
// Read-only direct-mapped instruction cache with a COMPARE/FETCH miss FSM.
// Define ICACHE_STATS_EN to add hit_count/miss_count outputs.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = ICACHE_SETS
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t    state;
  word_t            miss_addr;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  word_t            rd_data;
  logic             hit;
  logic             miss_start;
  logic             fill;

  assign req_idx = imemaddr[IDX_W+1:2];
  assign req_tag = imemaddr[31:IDX_W+2];

  icache_frames #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_frames (
    .CLK      (CLK),
    .nRST     (nRST),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill),
    .wr_idx   (miss_addr[IDX_W+1:2]),
    .wr_tag   (miss_addr[31:IDX_W+2]),
    .wr_data  (iload)
  );

  // NOTE: every output of this block is assigned a default first, so no latches are inferred.
  always_comb begin
    hit        = rd_valid && (rd_tag == req_tag);
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    miss_start = 1'b0;
    fill       = 1'b0;
    if (state == COMPARE) begin
      ihit       = imemREN && hit;
      imemload   = ihit ? rd_data : '0;
      miss_start = imemREN && !hit;
    end else begin
      iREN = 1'b1;
      iaddr = miss_addr;
      fill = !iwait;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= COMPARE;
      miss_addr <= '0;
    end else begin
      case (state)
        COMPARE: if (miss_start) begin
          miss_addr <= imemaddr & 32'hFFFF_FFFC;
          state     <= FETCH;
        end
        FETCH: if (!iwait) state <= COMPARE;
        default: state <= COMPARE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit) hit_count <= hit_count + 32'd1;
      if (miss_start) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboarded bench for icache: directed corner cases followed by random fetches,
// checked against a per-frame "which word is cached" model and a memory hash.
module tb_icache;
  import cpu_types_pkg::*;

  localparam int SETS = 16;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
`ifdef ICACHE_STATS_EN
  word_t hit_count;
  word_t miss_count;
`endif

  icache #(.SETS(SETS)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    word_t addr;
    word_t data;
    bit    was_hit;
  } exp_t;

  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  word_t fetch_q[$];
  bit    mvalid[SETS];
  word_t mword[SETS];
  int    exp_hits = 0;
  int    exp_misses = 0;
  int    next_wait = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t mem_word(input word_t byte_addr);
    if (byte_addr == 32'h0) return 32'h3C01_0001;
    return (byte_addr * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) begin
      mvalid[i] = 1'b0;
      mword[i]  = '0;
    end
    exp_q.delete();
    fetch_q.delete();
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // A miss loads the whole word into frame (word mod SETS) and costs one memory fetch.
  task automatic model_fill(input word_t addr);
    word_t w = addr >> 2;
    int    f = int'(w % SETS);
    mvalid[f] = 1'b1;
    mword[f]  = w;
    fetch_q.push_back(w << 2);
    exp_misses++;
  endtask

  task automatic predict(input word_t addr, output bit hit);
    word_t w = addr >> 2;
    int    f = int'(w % SETS);
    hit = mvalid[f] && (mword[f] == w);
    if (!hit) model_fill(addr);
    exp_q.push_back('{addr: addr, data: mem_word(w << 2), was_hit: hit});
    exp_hits++;
  endtask

  // Memory controller: holds iwait high for next_wait cycles of each request.
  initial begin
    int cnt = 0;
    iwait = 1'b1;
    iload = '0;
    forever begin
      @(negedge CLK);
      if (iREN && nRST) begin
        if (cnt < next_wait) begin
          iwait = 1'b1;
          cnt++;
        end else begin
          iwait = 1'b0;
          iload = mem_word(iaddr);
        end
      end else begin
        iwait = 1'b1;
        iload = '0;
        cnt   = 0;
      end
    end
  end

  // Monitor: pops the fetch queue on each new fetch and the response queue on each hit.
  initial begin
    bit    in_fetch = 1'b0;
    bit    saw_fetch = 1'b0;
    word_t cur_fetch = '0;
    exp_t  e;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        in_fetch  = 1'b0;
        saw_fetch = 1'b0;
      end else begin
        if (iREN) begin
          if (!in_fetch) begin
            if (fetch_q.size() == 0) check("unexpected_fetch", 32'd1, 32'd0);
            else cur_fetch = fetch_q.pop_front();
            in_fetch  = 1'b1;
            saw_fetch = 1'b1;
          end
          check("iaddr", iaddr, cur_fetch);
          check("ihit_in_fetch", 32'(ihit), 32'd0);
        end else begin
          in_fetch = 1'b0;
        end
        if (!imemREN) check("ihit_idle", 32'(ihit), 32'd0);
        if (ihit) begin
          if (exp_q.size() == 0) begin
            check("unexpected_hit", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("imemload", imemload, e.data);
            check("hit_vs_miss", 32'(saw_fetch), 32'(!e.was_hit));
          end
          saw_fetch = 1'b0;
        end else begin
          check("imemload_zero", imemload, 32'd0);
        end
      end
    end
  end

  task automatic wait_hit(output int cycles);
    cycles = 0;
    forever begin
      @(negedge CLK);
      if (ihit) return;
      cycles++;
      if (cycles > 60) begin
        check("hit_timeout", 32'd1, 32'd0);
        return;
      end
    end
  endtask

  task automatic fetch(input word_t addr, input int w);
    bit h;
    int cyc;
    @(posedge CLK);
    #1;
    next_wait = w;
    imemREN   = 1'b1;
    imemaddr  = addr;
    predict(addr, h);
    wait_hit(cyc);
    check("latency", word_t'(cyc), h ? 32'd0 : word_t'(w + 2));
  endtask

  task automatic idle(input int n);
    @(posedge CLK);
    #1;
    imemREN  = 1'b0;
    imemaddr = $urandom;
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_ihit"}, 32'(ihit), 32'd0);
    check({tag, "_imemload"}, imemload, 32'd0);
    check({tag, "_iREN"}, 32'(iREN), 32'd0);
    check({tag, "_iaddr"}, iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
    check({tag, "_hit_count"}, hit_count, 32'd0);
    check({tag, "_miss_count"}, miss_count, 32'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bit h;
    int cyc;
    model_reset();
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    repeat (2) @(negedge CLK);
    check_quiet_outputs("reset");
    #2 nRST = 1'b1;

    // Cold miss with two wait cycles, then a same-word hit.
    fetch(32'h0000_0000, 2);
    fetch(32'h0000_0000, 1);
    // Conflicting tag in frame 0 evicts word 0.
    fetch(32'h0000_0040, 1);
    fetch(32'h0000_0000, 0);
    // Byte offset ignored: 0x6 fetches word 0x4.
    fetch(32'h0000_0006, 1);
    fetch(32'h0000_0004, 0);
    idle(2);

    // Address change mid-fetch: 0x10 fill completes, then 0x20 misses.
    @(posedge CLK);
    #1;
    next_wait = 2;
    imemREN   = 1'b1;
    imemaddr  = 32'h0000_0010;
    model_fill(32'h0000_0010);
    @(posedge CLK);
    #1;
    imemaddr = 32'h0000_0020;
    predict(32'h0000_0020, h);
    wait_hit(cyc);
    fetch(32'h0000_0010, 0);
    fetch(32'h0000_0020, 0);

    // Reset in the middle of a fill.
    @(posedge CLK);
    #1;
    next_wait = 5;
    imemREN   = 1'b1;
    imemaddr  = 32'h0000_0080;
    fetch_q.push_back(32'h0000_0080);
    @(posedge CLK);
    #1;
    check("fetch_before_reset", 32'(iREN), 32'd1);
    #2;
    nRST    = 1'b0;
    imemREN = 1'b0;
    model_reset();
    #1;
    check_quiet_outputs("mid_fetch_reset");
    @(negedge CLK);
    #2 nRST = 1'b1;
    fetch(32'h0000_0000, 1);

    // Random traffic over a few tags so frames alias and evict.
    repeat (250) begin
      word_t addr;
      logic [25:0] tag;
      tag  = ($urandom_range(0, 4) == 4) ? 26'h3FF_FFFF : 26'($urandom_range(0, 3));
      addr = {tag, 4'($urandom_range(0, SETS - 1)), 2'($urandom_range(0, 3))};
      fetch(addr, $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end

    idle(3);
    check("exp_q_drained", word_t'(exp_q.size()), 32'd0);
    check("fetch_q_drained", word_t'(fetch_q.size()), 32'd0);
`ifdef ICACHE_STATS_EN
    check("hit_count", hit_count, word_t'(exp_hits));
    check("miss_count", miss_count, word_t'(exp_misses));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
